menu_ctrl: RTL and testbench



---
 rtl/menu_ctrl.sv | 170 +++++++++++++++++
 tb/tb_menu_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/menu_ctrl.sv
// menu_ctrl: SnakeWars top-level screen sequencer.
// Decodes button rises, walks MENU/SETTINGS/CONNECT/PLAY/RESULT/ERROR screens,
// drives the highlighted menu line, the banner text id and game start pulses.
// Ports:
//   clk, rst (async, active-low)
//   btn_up, btn_down, btn_enter : synchronized button levels
//   link_ok                     : UART peer link established (level)
//   game_end, game_result       : end-of-game pulse and outcome from the game core
//   screen, highlight, banner_text, start_single, start_multi, game_active : registered outputs
module menu_ctrl #(
  parameter int unsigned HOLD_CYCLES  = 32_500_000,
  parameter int unsigned CONN_TIMEOUT = 65_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_enter,
  input  logic       link_ok,
  input  logic       game_end,
  input  logic [1:0] game_result,
  output logic [2:0] screen,
  output logic [1:0] highlight,
  output logic [2:0] banner_text,
  output logic       start_single,
  output logic       start_multi,
  output logic       game_active
);

  localparam int unsigned CNT_W   = 27;
  localparam int unsigned HL_W    = 2;
  localparam int unsigned N_ITEMS = 3;

  localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] CONN_LAST = CNT_W'(CONN_TIMEOUT - 1);
  localparam logic [HL_W-1:0]  HL_LAST   = HL_W'(N_ITEMS - 1);

  typedef enum logic [2:0] {
    S_MENU        = 3'd0,
    S_SETTINGS    = 3'd1,
    S_CONNECT     = 3'd2,
    S_PLAY_SINGLE = 3'd3,
    S_PLAY_MULTI  = 3'd4,
    S_RESULT      = 3'd5,
    S_ERROR       = 3'd6
  } screen_t;

  screen_t          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [HL_W-1:0]  hl_d;
  logic [2:0]       banner_d, result_text;
  logic             start_single_d, start_multi_d, game_active_d;
  logic             prev_up, prev_down, prev_enter, armed;
  logic             rise_up, rise_down, rise_enter;

  // Rises are masked on the first edge after reset so a button held through
  // reset release is absorbed into the prev registers instead of firing.
  assign rise_up    = armed & btn_up    & ~prev_up;
  assign rise_down  = armed & btn_down  & ~prev_down;
  assign rise_enter = armed & btn_enter & ~prev_enter;

  assign screen = state_q;

  // Outcome to banner id; code 3 is shown as a draw.
  always_comb begin
    result_text = 3'd7;
    case (game_result)
      2'd0:    result_text = 3'd5;
      2'd1:    result_text = 3'd6;
      default: result_text = 3'd7;
    endcase
  end

  // Next-state, counter and output decode.
  always_comb begin
    state_d        = state_q;
    hl_d           = highlight;
    cnt_d          = '0;
    start_single_d = 1'b0;
    start_multi_d  = 1'b0;

    case (state_q)
      S_MENU: begin
        if (rise_enter) begin
          case (highlight)
            2'd0: begin
              state_d        = S_PLAY_SINGLE;
              start_single_d = 1'b1;
            end
            2'd1:    state_d = S_CONNECT;
            default: state_d = S_SETTINGS;
          endcase
        end else if (rise_up && !rise_down) begin
          hl_d = (highlight == '0) ? HL_LAST : highlight - 2'd1;
        end else if (rise_down && !rise_up) begin
          hl_d = (highlight == HL_LAST) ? '0 : highlight + 2'd1;
        end
      end
      S_SETTINGS: begin
        if (rise_enter) state_d = S_MENU;
      end
      S_CONNECT: begin
        cnt_d = cnt_q + 1'b1;
        // A link arriving on the timeout cycle still starts the game.
        if (link_ok) begin
          state_d       = S_PLAY_MULTI;
          start_multi_d = 1'b1;
        end else if (rise_enter) begin
          state_d = S_MENU;
        end else if (cnt_q == CONN_LAST) begin
          state_d = S_ERROR;
        end
      end
      S_PLAY_SINGLE: begin
        if (game_end) state_d = S_RESULT;
      end
      S_PLAY_MULTI: begin
        if (game_end)      state_d = S_RESULT;
        else if (!link_ok) state_d = S_ERROR;
      end
      S_RESULT, S_ERROR: begin
        // Enter is only honoured once the hold counter has saturated.
        cnt_d = (cnt_q == HOLD_MAX) ? cnt_q : cnt_q + 1'b1;
        if (rise_enter && cnt_q == HOLD_MAX) state_d = S_MENU;
      end
      default: state_d = S_MENU;
    endcase

    if (state_d != state_q) cnt_d = '0;

    case (state_d)
      S_SETTINGS: banner_d = 3'd4;
      S_ERROR:    banner_d = 3'd3;
      S_RESULT:   banner_d = (state_q == S_RESULT) ? banner_text : result_text;
      default:    banner_d = 3'd0;
    endcase

    game_active_d = (state_d == S_PLAY_SINGLE) || (state_d == S_PLAY_MULTI);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_MENU;
      cnt_q        <= '0;
      highlight    <= '0;
      banner_text  <= '0;
      start_single <= 1'b0;
      start_multi  <= 1'b0;
      game_active  <= 1'b0;
      prev_up      <= 1'b0;
      prev_down    <= 1'b0;
      prev_enter   <= 1'b0;
      armed        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      highlight    <= hl_d;
      banner_text  <= banner_d;
      start_single <= start_single_d;
      start_multi  <= start_multi_d;
      game_active  <= game_active_d;
      prev_up      <= btn_up;
      prev_down    <= btn_down;
      prev_enter   <= btn_enter;
      armed        <= 1'b1;
    end
  end

endmodule

// File: tb/tb_menu_ctrl.sv
// Self-checking bench for menu_ctrl: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a reference model.
module tb_menu_ctrl;

  localparam int unsigned HOLD = 8;
  localparam int unsigned CONN = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_enter = 1'b0;
  logic       link_ok = 1'b0, game_end = 1'b0;
  logic [1:0] game_result = 2'd0;
  logic [2:0] screen;
  logic [1:0] highlight;
  logic [2:0] banner_text;
  logic       start_single, start_multi, game_active;

  menu_ctrl #(.HOLD_CYCLES(HOLD), .CONN_TIMEOUT(CONN)) dut (
    .clk(clk), .rst(rst),
    .btn_up(btn_up), .btn_down(btn_down), .btn_enter(btn_enter),
    .link_ok(link_ok), .game_end(game_end), .game_result(game_result),
    .screen(screen), .highlight(highlight), .banner_text(banner_text),
    .start_single(start_single), .start_multi(start_multi), .game_active(game_active)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: screen codes, elapsed cycles since entering a screen.
  int m_scr, m_hl, m_ban, m_res_ban, m_cyc;
  bit m_ss, m_sm, m_ga;
  bit m_pu, m_pd, m_pe;

  task automatic model_reset(input bit u, input bit d, input bit e);
    m_scr = 0; m_hl = 0; m_ban = 0; m_res_ban = 0; m_cyc = 0;
    m_ss = 0; m_sm = 0; m_ga = 0;
    m_pu = u; m_pd = d; m_pe = e;
  endtask

  task automatic model_step(input bit u, input bit d, input bit e,
                            input bit lk, input bit ge, input int gr);
    bit ru, rd, re;
    int nxt;
    ru = u && !m_pu; rd = d && !m_pd; re = e && !m_pe;
    m_pu = u; m_pd = d; m_pe = e;
    nxt = m_scr; m_ss = 0; m_sm = 0;
    case (m_scr)
      0: begin
        if (re) begin
          if (m_hl == 0) begin nxt = 3; m_ss = 1; end
          else if (m_hl == 1) nxt = 2;
          else nxt = 1;
        end else if (ru != rd) begin
          m_hl = ru ? (m_hl + 2) % 3 : (m_hl + 1) % 3;
        end
      end
      1: if (re) nxt = 0;
      2: begin
        if (lk) begin nxt = 4; m_sm = 1; end
        else if (re) nxt = 0;
        else if (m_cyc + 1 >= int'(CONN)) nxt = 6;
      end
      3, 4: begin
        if (ge) begin
          nxt = 5;
          m_res_ban = (gr == 0) ? 5 : (gr == 1) ? 6 : 7;
        end else if (m_scr == 4 && !lk) nxt = 6;
      end
      default: if (re && m_cyc >= int'(HOLD)) nxt = 0;
    endcase
    m_cyc = (nxt != m_scr) ? 0 : m_cyc + 1;
    m_scr = nxt;
    m_ga  = (nxt == 3 || nxt == 4);
    m_ban = (nxt == 1) ? 4 : (nxt == 6) ? 3 : (nxt == 5) ? m_res_ban : 0;
  endtask

  task automatic check(input string name, input logic [2:0] e_scr, input logic [1:0] e_hl,
                       input logic [2:0] e_ban, input logic e_ss, input logic e_sm,
                       input logic e_ga);
    logic [11:0] act, exp;
    act = {screen, highlight, banner_text, start_single, start_multi, game_active};
    exp = {e_scr, e_hl, e_ban, e_ss, e_sm, e_ga};
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t: got scr=%0d hl=%0d ban=%0d ss=%0b sm=%0b ga=%0b, want scr=%0d hl=%0d ban=%0d ss=%0b sm=%0b ga=%0b",
               name, $time, screen, highlight, banner_text, start_single, start_multi, game_active,
               e_scr, e_hl, e_ban, e_ss, e_sm, e_ga);
    end
  endtask

  task automatic check_model(input string name);
    check(name, 3'(m_scr), 2'(m_hl), 3'(m_ban), m_ss, m_sm, m_ga);
  endtask

  // Apply inputs, clock once, advance the model, settle just past the edge.
  task automatic drive(input bit u, input bit d, input bit e, input bit lk,
                       input bit ge, input logic [1:0] gr);
    btn_up = u; btn_down = d; btn_enter = e;
    link_ok = lk; game_end = ge; game_result = gr;
    @(posedge clk);
    model_step(u, d, e, lk, ge, int'(gr));
    #1;
  endtask

  task automatic step(input string name, input bit u, input bit d, input bit e,
                      input bit lk, input bit ge, input logic [1:0] gr);
    drive(u, d, e, lk, ge, gr);
    check_model(name);
  endtask

  task automatic do_reset(input bit u, input bit d, input bit e, input bit lk);
    rst = 1'b0;
    btn_up = u; btn_down = d; btn_enter = e; link_ok = lk; game_end = 1'b0;
    #1;
    model_reset(u, d, e);
    check("reset", 3'd0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step("post_reset", u, d, e, lk, 1'b0, 2'd0);
  endtask

  typedef struct {
    bit u, d, e, lk, ge;
    logic [1:0] gr;
    logic [2:0] scr;
    logic [1:0] hl;
    logic [2:0] ban;
    bit ss, sm, ga;
  } vec_t;

  function automatic vec_t v(input int u, input int d, input int e, input int lk,
                             input int ge, input int gr, input int scr, input int hl,
                             input int ban, input int ss, input int sm, input int ga);
    vec_t r;
    r.u = 1'(u); r.d = 1'(d); r.e = 1'(e); r.lk = 1'(lk); r.ge = 1'(ge);
    r.gr = 2'(gr); r.scr = 3'(scr); r.hl = 2'(hl); r.ban = 3'(ban);
    r.ss = 1'(ss); r.sm = 1'(sm); r.ga = 1'(ga);
    return r;
  endfunction

  vec_t tbl[$];

  initial begin
    bit lk;
    // Directed table: held-through-reset button, highlight wrap, single game, result hold.
    tbl.push_back(v(0,1,0,0,0,0, 0,0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0, 0,0,0,0,0,0));
    tbl.push_back(v(0,1,0,0,0,0, 0,1,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0, 0,1,0,0,0,0));
    tbl.push_back(v(1,0,0,0,0,0, 0,0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0, 0,0,0,0,0,0));
    tbl.push_back(v(1,0,0,0,0,0, 0,2,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0, 0,2,0,0,0,0));
    tbl.push_back(v(0,1,0,0,0,0, 0,0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0, 0,0,0,0,0,0));
    tbl.push_back(v(0,1,0,0,0,0, 0,1,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0, 0,1,0,0,0,0));
    tbl.push_back(v(0,1,0,0,0,0, 0,2,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0, 0,2,0,0,0,0));
    tbl.push_back(v(1,1,0,0,0,0, 0,2,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0, 0,2,0,0,0,0));
    tbl.push_back(v(0,1,0,0,0,0, 0,0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0, 0,0,0,0,0,0));
    tbl.push_back(v(0,0,1,0,0,0, 3,0,0,1,0,1));
    tbl.push_back(v(0,0,0,0,0,0, 3,0,0,0,0,1));
    tbl.push_back(v(1,1,1,0,0,0, 3,0,0,0,0,1));
    tbl.push_back(v(0,0,0,0,1,1, 5,0,6,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0, 5,0,6,0,0,0));
    tbl.push_back(v(0,0,1,0,0,0, 5,0,6,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0, 5,0,6,0,0,0));
    tbl.push_back(v(0,0,1,0,0,0, 5,0,6,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0, 5,0,6,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0, 5,0,6,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0, 5,0,6,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0, 5,0,6,0,0,0));
    tbl.push_back(v(0,0,1,0,0,0, 0,0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0, 0,0,0,0,0,0));

    repeat (2) @(posedge clk);
    do_reset(1'b0, 1'b1, 1'b0, 1'b0);

    foreach (tbl[i]) begin
      drive(tbl[i].u, tbl[i].d, tbl[i].e, tbl[i].lk, tbl[i].ge, tbl[i].gr);
      check($sformatf("vec%0d", i), tbl[i].scr, tbl[i].hl, tbl[i].ban,
            tbl[i].ss, tbl[i].sm, tbl[i].ga);
    end

    // Connection timeout from highlight 1.
    step("to_hl1", 0,1,0,0,0,2'd0);
    step("rel", 0,0,0,0,0,2'd0);
    drive(0,0,1,0,0,2'd0);
    check("conn_enter", 3'd2, 2'd1, 3'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < int'(CONN) - 1; i++) begin
      drive(0,0,0,0,0,2'd0);
      check("conn_wait", 3'd2, 2'd1, 3'd0, 1'b0, 1'b0, 1'b0);
    end
    drive(0,0,0,0,0,2'd0);
    check("conn_timeout", 3'd6, 2'd1, 3'd3, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < int'(HOLD); i++) begin
      drive(0,0,0,0,0,2'd0);
      check("err_hold", 3'd6, 2'd1, 3'd3, 1'b0, 1'b0, 1'b0);
    end
    drive(0,0,1,0,0,2'd0);
    check("err_exit", 3'd0, 2'd1, 3'd0, 1'b0, 1'b0, 1'b0);
    step("rel", 0,0,0,0,0,2'd0);

    // Link comes up on the fourth connect cycle, then drops during play.
    drive(0,0,1,0,0,2'd0);
    check("conn_enter2", 3'd2, 2'd1, 3'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("conn_wait2", 0,0,0,0,0,2'd0);
    drive(0,0,0,1,0,2'd0);
    check("link_up", 3'd4, 2'd1, 3'd0, 1'b0, 1'b1, 1'b1);
    drive(0,0,0,1,0,2'd0);
    check("multi_hold", 3'd4, 2'd1, 3'd0, 1'b0, 1'b0, 1'b1);
    drive(0,0,0,0,0,2'd0);
    check("link_drop", 3'd6, 2'd1, 3'd3, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < int'(HOLD); i++) step("err_hold2", 0,0,0,0,0,2'd0);
    step("err_exit2", 0,0,1,0,0,2'd0);
    step("rel", 0,0,0,0,0,2'd0);

    // Link drop coinciding with game_end: result wins.
    step("conn_enter3", 0,0,1,1,0,2'd0);
    drive(0,0,0,1,0,2'd0);
    check("link_up3", 3'd4, 2'd1, 3'd0, 1'b0, 1'b1, 1'b1);
    drive(0,0,0,0,1,2'd0);
    check("drop_and_end", 3'd5, 2'd1, 3'd5, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < int'(HOLD); i++) step("res_hold", 0,0,0,0,0,2'd0);
    step("res_exit", 0,0,1,0,0,2'd0);
    step("rel", 0,0,0,0,0,2'd0);

    // Asynchronous reset in the middle of CONNECT.
    step("conn_enter4", 0,0,1,0,0,2'd0);
    for (int i = 0; i < 3; i++) step("conn_wait4", 0,0,0,0,0,2'd0);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst", 3'd0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    do_reset(1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized run against the model.
    lk = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(599) == 0) begin
        do_reset(1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)), lk);
      end else begin
        if ($urandom_range(7) == 0) lk = ~lk;
        step("rand", 1'($urandom_range(3) == 0), 1'($urandom_range(3) == 0),
             1'($urandom_range(2) == 0), lk, 1'($urandom_range(15) == 0),
             2'($urandom_range(3)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
